// File: rtl/rom_loader.sv
// Streams a host byte image into program memory port A from BASE_ADDR upward, holding the CPU until the load completes.
// Optional build macro ROM_LOADER_CLEAR_EN adds a zero-fill pass over BASE_ADDR..CLEAR_TOP before each load.
module rom_loader #(
  parameter int                 ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 12'h200,
  parameter logic [ADDR_W-1:0]  CLEAR_TOP = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [11:0]       byte_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef ROM_LOADER_CLEAR_EN
    S_CLEAR = 2'd1,
`endif
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_END = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              full_q, full_d;      // last address already written; further bytes are dropped
  logic              overflow_q, overflow_d;
  logic [11:0]       count_q, count_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              start_ok;
  logic              hs;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign hs       = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
`ifdef ROM_LOADER_CLEAR_EN
          state_d = S_CLEAR;
`else
          state_d = S_LOAD;
`endif
        end
      end
`ifdef ROM_LOADER_CLEAR_EN
      S_CLEAR: begin
        if (ptr_q == CLEAR_TOP) state_d = S_LOAD;
      end
`endif
      S_LOAD: begin
        if (hs && in_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = (state_q == S_LOAD);
    done     = (state_q == S_DONE);
    cpu_hold = (state_q != S_DONE);
`ifdef ROM_LOADER_CLEAR_EN
    busy     = (state_q == S_CLEAR) || (state_q == S_LOAD);
`else
    busy     = (state_q == S_LOAD);
`endif
  end

  // Datapath: pointer, counters and the registered memory port
  always_comb begin
    ptr_d       = ptr_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    mem_en_d    = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    if (start_ok) begin
      ptr_d      = BASE_ADDR;
      full_d     = 1'b0;
      overflow_d = 1'b0;
      count_d    = 12'd0;
    end

`ifdef ROM_LOADER_CLEAR_EN
    if (state_q == S_CLEAR) begin
      mem_en_d    = 1'b1;
      mem_write_d = 1'b1;
      mem_addr_d  = ptr_q;
      mem_data_d  = 8'h00;
      ptr_d       = (ptr_q == CLEAR_TOP) ? BASE_ADDR : ptr_q + 1'b1;
    end
`endif

    if ((state_q == S_LOAD) && hs) begin
      if (full_q) begin
        overflow_d = 1'b1;
      end else begin
        mem_en_d    = 1'b1;
        mem_write_d = 1'b1;
        mem_addr_d  = ptr_q;
        mem_data_d  = in_data;
        count_d     = (count_q == 12'hFFF) ? count_q : count_q + 12'd1;
        if (ptr_q == PTR_END) full_d = 1'b1;
        else                  ptr_d  = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= BASE_ADDR;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= 12'd0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= 8'h00;
    end else begin
      ptr_q       <= ptr_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      mem_en_q    <= mem_en_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

`ifndef ROM_LOADER_CLEAR_EN
  logic unused_clear_top;
  assign unused_clear_top = ^CLEAR_TOP;
`endif

  assign mem_en     = mem_en_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign overflow   = overflow_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized self-checking bench for rom_loader: an address/count model predicts every write strobe and status flag.
// Honours ROM_LOADER_CLEAR_EN by checking the zero-fill pass after each start.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mem_en;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [11:0] byte_count;

  rom_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: next address to write (beyond 0xFFF means memory is full), bytes written, dropped flag.
  logic [7:0] tx_q[$];
  int         m_ptr;
  int         m_cnt;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_mem_en"},    {31'd0, mem_en},    32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"},  {20'd0, mem_addr},  32'd0);
    chk({tag, "_mem_data"},  {24'd0, mem_data},  32'd0);
    chk({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd1);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
    chk({tag, "_overflow"},  {31'd0, overflow},  32'd0);
    chk({tag, "_count"},     {20'd0, byte_count}, 32'd0);
  endtask

  task automatic fill_random(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_ptr = 'h200;
    m_cnt = 0;
    m_ovf = 1'b0;
    chk("start_busy",     {31'd0, busy},      32'd1);
    chk("start_cpu_hold", {31'd0, cpu_hold},  32'd1);
    chk("start_done",     {31'd0, done},      32'd0);
    chk("start_count",    {20'd0, byte_count}, 32'd0);
    chk("start_overflow", {31'd0, overflow},  32'd0);
`ifdef ROM_LOADER_CLEAR_EN
    for (int k = 0; k < 3584; k++) begin
      chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("clear_mem_en",    {31'd0, mem_en},    32'd1);
      chk("clear_mem_write", {31'd0, mem_write}, 32'd1);
      chk("clear_addr",      {20'd0, mem_addr},  32'h200 + 32'(k));
      chk("clear_data",      {24'd0, mem_data},  32'd0);
    end
`endif
  endtask

  // mode 0: valid every cycle, 1: alternating 1,0,1,0, 2: random gaps plus stray start pulses
  task automatic run_load(input int mode, input bit with_last);
    int idx;
    int n;
    int cyc;
    bit v;
    bit exp_w;
    idx = 0;
    cyc = 0;
    n = tx_q.size();
    while (idx < n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      in_valid = v;
      in_data  = v ? tx_q[idx] : 8'($urandom);
      in_last  = v ? (with_last && (idx == n - 1)) : 1'($urandom_range(0, 1));
      start    = (mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
      chk("load_in_ready", {31'd0, in_ready}, 32'd1);
      chk("load_busy",     {31'd0, busy},     32'd1);
      tick();
      exp_w = v && (m_ptr <= 'hFFF);
      chk("wr_mem_en",    {31'd0, mem_en},    {31'd0, exp_w});
      chk("wr_mem_write", {31'd0, mem_write}, {31'd0, exp_w});
      if (exp_w) begin
        chk("wr_addr", {20'd0, mem_addr}, 32'(m_ptr));
        chk("wr_data", {24'd0, mem_data}, {24'd0, tx_q[idx]});
      end
      if (v) begin
        if (m_ptr <= 'hFFF) begin
          m_ptr++;
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
        idx++;
      end
      chk("byte_count", {20'd0, byte_count}, (m_cnt > 4095) ? 32'd4095 : 32'(m_cnt));
      chk("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    if (with_last) begin
      chk("end_done",     {31'd0, done},     32'd1);
      chk("end_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("end_busy",     {31'd0, busy},     32'd0);
      chk("end_in_ready", {31'd0, in_ready}, 32'd0);
    end
  endtask

  initial begin
    // Power-on reset, then the first cycle after release
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk_reset_values("por");

    // Directed three-byte image
    tx_q.delete();
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'hAB);
    do_start();
    run_load(0, 1'b1);

    // DONE ignores further stream bytes
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold_mem_en", {31'd0, mem_en},   32'd0);
      chk("done_hold_done",   {31'd0, done},     32'd1);
      chk("done_hold_ready",  {31'd0, in_ready}, 32'd0);
      chk("done_hold_count",  {20'd0, byte_count}, 32'd3);
    end
    in_valid = 1'b0;

    // Alternating valid, stray in_last on idle cycles
    fill_random(2);
    do_start();
    run_load(1, 1'b1);

    // Random gaps, random data, ignored start pulses
    for (int r = 0; r < 3; r++) begin
      fill_random(20 + int'($urandom_range(0, 30)));
      do_start();
      run_load(2, 1'b1);
    end

    // Fill to the end of memory and one byte past it
    fill_random(3585);
    do_start();
    run_load(0, 1'b1);
    tick();
    chk("ovf_sticky",      {31'd0, overflow},  32'd1);
    chk("ovf_count",       {20'd0, byte_count}, 32'd3584);
    chk("ovf_no_wrap_wr",  {31'd0, mem_en},    32'd0);

    // Asynchronous reset in the middle of a load
    fill_random(10);
    do_start();
    run_load(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midload_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_values("post_rst");
    fill_random(2);
    do_start();
    run_load(0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
